ucsbece154a_mem_arbiter: RTL
============================

# ucsbece154a_mem_arbiter

Two-port arbiter that shares the processor's single unified instruction/data memory between the multicycle CPU (port 0) and a debug/loader master (port 1). It grants one transaction at a time, drives the memory port, waits a fixed read latency, and returns a completion pulse with read data to the owner. The multicycle controller sees arbitration loss as a withheld `m0_ready` and holds its request until it is granted.

## Interface
- `LATENCY`, default 2: cycles from grant to valid `mem_rdata`. Legal range 1..7.
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `m0_valid`  in  1  CPU request pending
- `m0_we`  in  1  CPU request is a write
- `m0_addr`  in  32  CPU byte address
- `m0_wdata`  in  32  CPU write data
- `m0_ready`  out  1  CPU request granted this cycle
- `m0_done`  out  1  CPU transaction completes this cycle
- `m0_rdata`  out  32  CPU read data, valid with `m0_done`
- `m1_valid`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ready`, `m1_done`, `m1_rdata`: same as port 0, for the debug master
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data, valid `LATENCY` cycles after `mem_en`

## Operation
- The FSM has two states, IDLE and WAIT. It also holds a 3-bit latency counter `cnt`, a 1-bit `owner`, and a 1-bit `last` (the last-granted port).
- **IDLE:**
  - If only one port is valid, that port wins.
  - If both are valid, the port not equal to `last` wins (round-robin).
  - If neither is valid, nothing happens.
  - On a grant in cycle T:
    - The winner's `mx_ready` is 1 combinationally in T.
    - `mem_en`=1 in T, and `mem_we`/`mem_addr`/`mem_wdata` are driven from the winner in T.
    - At the end of T: `owner`←winner, `last`←winner, `cnt`←1, go to WAIT.
  - The loser's `ready`=0. The loser must hold its request stable; it is served on a later IDLE cycle.
- **WAIT:**
  - Both ready outputs=0, `mem_en`=0, `mem_we`=0.
  - Requests presented in WAIT are ignored and not queued.
  - `cnt` increments each cycle.
  - In the cycle where `cnt`==LATENCY:
    - The owner's `done`=1.
    - For reads, owner's `rdata`=`mem_rdata` (combinational pass-through).
    - For writes, owner's `rdata`=0.
    - Next state is IDLE.
- The registered bit `wr` records `m*_we` at grant. It selects the read or write `rdata` behavior.
- Non-owner `done`=0 and `rdata`=0 at all times.
- When `mem_en`=0, `mem_addr`/`mem_wdata` carry the last granted values; they are registered at grant.
- The memory commits writes on the rising edge ending cycle T.
- `mx_ready` depends combinationally on `mx_valid`. No combinational path exists from any `ready` back to any `valid`.

## Timing
- Grant occurs in the same cycle as the request when the FSM is in IDLE.
- Completion (`done`) occurs at T+LATENCY.
- The earliest next grant is T+LATENCY+1. Peak throughput is one transaction per LATENCY+1 cycles.
- Reset: at the edge where `reset`=1, state←IDLE, `cnt`←0, `owner`←0, `last`←1, `wr`←0, so port 0 wins the first conflict.
- While `reset` is high, `m0_ready`, `m1_ready`, `mem_en`, `mem_we`, `m0_done` and `m1_done` are forced to 0, and `rdata` outputs are 0.
- Reset during WAIT aborts the transaction: no `done` is ever issued for it. A write already committed at its grant edge stays committed.
- Simultaneous event: a requester whose `done` is high in a cycle may present a new request in that same cycle, but the new request is not granted until the following IDLE cycle.
- LATENCY=1: WAIT lasts exactly one cycle, and `done` falls in T+1.

## Test plan
- **Single read:** LATENCY=2. After reset, `m0_valid`=1, `m0_addr`=0x10 at T; memory model returns 0xDEADBEEF at T+2 → `m0_ready`=1 and `mem_en`=1 with `mem_addr`=0x10 at T; `m0_done`=1 with `m0_rdata`=0xDEADBEEF at T+2; `m1_done`=0 throughout.
- **Conflict round-robin:** both ports continuously valid from T after reset → grants at T (m0), T+3 (m1), T+6 (m0), T+9 (m1); each port is held off exactly 3 cycles.
- **Write:** `m1_we`=1, `m1_addr`=0x20, `m1_wdata`=0x12345678 at T → `mem_en`=`mem_we`=1 with those values at T; `m1_done`=1 with `m1_rdata`=0 at T+2; `m0_ready`=0 at T+1 and T+2 despite `m0_valid`=1.
- **Reset mid-operation:** grant m1 at T; reset high at T+1 → no `done` in T+2; first conflict after reset is granted to m0.
- **LATENCY=1 back-to-back:** m0 reads 0x0, 0x4, 0x8 held valid continuously → grants at T, T+2, T+4; `done` at T+1, T+3, T+5 with the matching data.
- **Request during WAIT:** m1 raises valid at T+1 while m0 is owner (LATENCY=2) → `m1_ready`=0 at T+1 and T+2; m1 is granted at T+3.

Source files
------------

// File: rtl/ucsbece154a_mem_arbiter.sv
// Round-robin two-port arbiter sharing the unified memory between the CPU (port 0)
// and a debug/loader master (port 1); one transaction in flight, fixed read latency.
module ucsbece154a_mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = 3;
  localparam int unsigned DW = 32;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            owner, last, wr;
  logic [DW-1:0]   addr_q, wdata_q;
  logic            grant, winner, done;
  logic [DW-1:0]   rd;

  // Arbitration and next-state; everything is suppressed while reset is high
  always_comb begin
    grant   = 1'b0;
    winner  = 1'b0;
    done    = 1'b0;
    state_n = state;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          grant  = m0_valid | m1_valid;
          winner = (m0_valid & m1_valid) ? ~last : m1_valid;
          if (grant) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CW'(LATENCY)) begin
            done    = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Memory port is driven straight from the winner in the grant cycle, else held
  always_comb begin
    m0_ready  = grant & ~winner;
    m1_ready  = grant & winner;
    mem_en    = grant;
    mem_we    = grant & (winner ? m1_we : m0_we);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (grant) begin
      mem_addr  = winner ? m1_addr  : m0_addr;
      mem_wdata = winner ? m1_wdata : m0_wdata;
    end
    m0_done  = done & ~owner;
    m1_done  = done & owner;
    rd       = wr ? '0 : mem_rdata;
    m0_rdata = m0_done ? rd : '0;
    m1_rdata = m1_done ? rd : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      wr      <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner   <= winner;
        last    <= winner;
        wr      <= mem_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        cnt     <= CW'(1);
      end else if (state == S_WAIT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
